// File: rtl/riscv_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package riscv_loader_pkg;

   typedef enum logic [2:0] {
      HDR   = 3'd0,
      LOAD  = 3'd1,
      CSUM  = 3'd2,
      DONE  = 3'd3,
      ERROR = 3'd4
   } state_t;

   localparam int HDR_BYTES  = 4;
   localparam int CSUM_BYTES = 4;

   typedef logic [31:0] word_t;

endpackage

// File: rtl/riscv_byte_packer.sv
// Little-endian 8->32 assembler; word_valid pulses in the cycle the 4th byte is accepted.
module riscv_byte_packer
   import riscv_loader_pkg::*;
(
   input  logic       clock,
   input  logic       nreset,
   input  logic       clear,
   input  logic       accept,
   input  logic [7:0] din,
   output word_t      word,
   output logic       word_valid
);

   logic [1:0]  cnt;
   logic [23:0] lo;

   always_ff @(posedge clock) begin
      if (!nreset || clear) begin
         cnt <= 2'd0;
         lo  <= 24'd0;
      end else if (accept) begin
         case (cnt)
            2'd0:    lo[7:0]   <= din;
            2'd1:    lo[15:8]  <= din;
            2'd2:    lo[23:16] <= din;
            default: lo        <= lo;
         endcase
         cnt <= cnt + 2'd1;
      end
   end

   // Top byte bypasses the register so the full word is visible on the completing cycle
   assign word       = {din, lo};
   assign word_valid = accept && (cnt == 2'd3);

endmodule

// File: rtl/riscv_prog_loader.sv
// Boot loader: receives length, payload and checksum, fills imem, then releases the core.
//
//  state | meaning
//  HDR   | collecting the 4-byte word count
//  LOAD  | collecting payload words, one imem write per word
//  CSUM  | collecting the 4-byte checksum
//  DONE  | image verified, core released
//  ERROR | overflow or checksum mismatch, core held
module riscv_prog_loader
   import riscv_loader_pkg::*;
#(
   parameter int IMEM_DEPTH = 1024,
   parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
   input  logic              clock,
   input  logic              nreset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output word_t             imem_wdata,
   output logic              core_nreset,
   output logic              load_done,
   output logic              load_error
);

   state_t            state, state_nxt;
   logic              accept;
   logic              word_valid;
   word_t             word;
   logic              pack_clear;
   logic [ADDR_W:0]   remaining;
   logic [ADDR_W-1:0] word_idx;
   word_t             sum;

   assign accept     = rx_valid && rx_ready;
   assign pack_clear = (state == DONE) || (state == ERROR);

   riscv_byte_packer u_packer (
      .clock      (clock),
      .nreset     (nreset),
      .clear      (pack_clear),
      .accept     (accept),
      .din        (rx_data),
      .word       (word),
      .word_valid (word_valid)
   );

   always_ff @(posedge clock) begin
      if (!nreset) state <= HDR;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         HDR: if (word_valid) begin
            if (word > 32'(IMEM_DEPTH)) state_nxt = ERROR;
            else if (word == 32'd0)     state_nxt = CSUM;
            else                        state_nxt = LOAD;
         end
         LOAD: if (word_valid && remaining == 1) state_nxt = CSUM;
         CSUM: if (word_valid) state_nxt = (word == sum) ? DONE : ERROR;
         default: state_nxt = state;
      endcase
   end

   // Remaining-word down-counter, address counter and running checksum
   always_ff @(posedge clock) begin
      if (!nreset) begin
         remaining <= '0;
         word_idx  <= '0;
         sum       <= '0;
      end else if (word_valid) begin
         if (state == HDR) begin
            remaining <= word[ADDR_W:0];
         end else if (state == LOAD) begin
            remaining <= remaining - 1'b1;
            word_idx  <= word_idx + 1'b1;
            sum       <= sum + word;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!nreset) begin
         imem_we     <= 1'b0;
         imem_addr   <= '0;
         imem_wdata  <= '0;
         rx_ready    <= 1'b0;
         core_nreset <= 1'b0;
         load_done   <= 1'b0;
         load_error  <= 1'b0;
      end else begin
         imem_we     <= (state == LOAD) && word_valid;
         if ((state == LOAD) && word_valid) begin
            imem_addr  <= word_idx;
            imem_wdata <= word;
         end
         rx_ready    <= (state_nxt == HDR) || (state_nxt == LOAD) || (state_nxt == CSUM);
         core_nreset <= (state_nxt == DONE);
         load_done   <= (state_nxt == DONE);
         load_error  <= (state_nxt == ERROR);
      end
   end

endmodule
